// File: rtl/can_pkg.sv
// Shared CAN definitions: bus levels, default stuffing run length and the
// stuffer state encoding. The receive-side destuffer uses the same enum.
package can_pkg;

    // Bus levels on the TX/RX pins.
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    // Number of equal consecutive bits that forces a complementary stuff bit.
    localparam int STUFF_LEN = 5;

    // Stuffer/destuffer state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STUFF = 2'd2
    } stuff_state_e;

endpackage

// File: rtl/can_tx_stuffer.sv
// Transmit-side CAN bit stuffer.
//
// One frame bit is taken per bit-time on the SP strobe and driven onto TX.
// Inside the stuffing region (F_STF=1) a complementary stuff bit is inserted
// after STUFF_LEN equal consecutive bits; the stuff bit then starts the next
// run.
//
// Handshake: tx_ready = SP & ~stuff_due. A bit is consumed on the cycle
// where tx_valid & tx_ready are both high. tx_ready is never high off-strobe,
// so the serializer must hold tx_bit/tx_valid until a strobe consumes it.
// A strobe that finds tx_valid low still "consumes" a slot: TX sends
// recessive, that 1 is counted like data in RUN, and underrun pulses.
//
// o_state exposes the FSM state for observation; it has no functional use.
module can_tx_stuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = can_pkg::STUFF_LEN,
    parameter int CNT_W     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SP,
    input  logic       F_STF,
    input  logic       tx_bit,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       stuff_ins,
    output logic       underrun,
    output logic [1:0] o_state
);

    // Registered state.
    stuff_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev;
    logic             r_stuff_due;
    logic             r_tx;
    logic             r_stuff_ins;
    logic             r_underrun;

    // Next-state values.
    stuff_state_e     w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_nxt_prev;
    logic             w_nxt_stuff_due;
    logic             w_nxt_tx;
    logic             w_nxt_stuff_ins;
    logic             w_nxt_underrun;

    // Helpers.
    logic             w_bit;
    logic             w_run_cnt_hit;
    logic [CNT_W-1:0] w_run_cnt;

    // A missing data bit is sent as recessive.
    assign w_bit = tx_valid ? tx_bit : CAN_RECESSIVE;

    // Length of the current run if w_bit is appended. The counter never
    // exceeds STUFF_LEN-1 while in RUN, so the increment cannot wrap.
    assign w_run_cnt     = (w_bit == r_prev) ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
    assign w_run_cnt_hit = (w_run_cnt == CNT_W'(STUFF_LEN));

    // Data is accepted on a strobe unless a stuff bit owns this bit-time.
    assign tx_ready = SP & ~r_stuff_due;

    assign TX        = r_tx;
    assign stuff_ins = r_stuff_ins;
    assign underrun  = r_underrun;
    assign o_state   = r_state;

    // Next-state and output decode; everything holds except on SP.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_prev      = r_prev;
        w_nxt_stuff_due = r_stuff_due;
        w_nxt_tx        = r_tx;
        w_nxt_stuff_ins = r_stuff_ins;
        w_nxt_underrun  = 1'b0;

        if (SP) begin
            w_nxt_stuff_ins = 1'b0;
            case (r_state)
                IDLE: begin
                    // Pass-through; a valid bit inside the region opens a run.
                    w_nxt_tx       = w_bit;
                    w_nxt_underrun = ~tx_valid;
                    if (F_STF && tx_valid) begin
                        w_nxt_prev  = w_bit;
                        w_nxt_cnt   = CNT_W'(1);
                        w_nxt_state = RUN;
                    end
                end

                RUN: begin
                    // Every strobe sends and counts one bit. A completed run
                    // always schedules its stuff bit, even if the region
                    // closes on this strobe.
                    w_nxt_tx       = w_bit;
                    w_nxt_underrun = ~tx_valid;
                    w_nxt_prev     = w_bit;
                    w_nxt_cnt      = w_run_cnt;
                    if (w_run_cnt_hit) begin
                        w_nxt_stuff_due = 1'b1;
                        w_nxt_state     = STUFF;
                    end else if (!F_STF) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = IDLE;
                    end
                end

                STUFF: begin
                    // The stuff bit is the first bit of the next run.
                    w_nxt_tx        = ~r_prev;
                    w_nxt_stuff_ins = 1'b1;
                    w_nxt_prev      = ~r_prev;
                    w_nxt_cnt       = CNT_W'(1);
                    w_nxt_stuff_due = 1'b0;
                    if (F_STF) begin
                        w_nxt_state = RUN;
                    end else begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = IDLE;
                    end
                end

                default: begin
                    w_nxt_state     = IDLE;
                    w_nxt_cnt       = '0;
                    w_nxt_stuff_due = 1'b0;
                end
            endcase
        end
    end

    // State register; reset discards any pending stuff bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_prev      <= CAN_RECESSIVE;
            r_stuff_due <= 1'b0;
            r_tx        <= CAN_RECESSIVE;
            r_stuff_ins <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_prev      <= w_nxt_prev;
            r_stuff_due <= w_nxt_stuff_due;
            r_tx        <= w_nxt_tx;
            r_stuff_ins <= w_nxt_stuff_ins;
            r_underrun  <= w_nxt_underrun;
        end
    end

endmodule

// File: tb/tb_can_tx_stuffer.sv
// Testbench for can_tx_stuffer: directed scenarios plus randomized frames,
// checked against a reference model that works on the emitted bit history.
module tb_can_tx_stuffer;

  localparam int L = 5;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic SP = 1'b0;
  logic F_STF = 1'b0;
  logic tx_bit = 1'b0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic TX;
  logic stuff_ins;
  logic underrun;
  logic [1:0] dbg_state;

  can_tx_stuffer #(.STUFF_LEN(L), .CNT_W(3)) dut (
    .clock(clock),
    .reset(reset),
    .SP(SP),
    .F_STF(F_STF),
    .tx_bit(tx_bit),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TX(TX),
    .stuff_ins(stuff_ins),
    .underrun(underrun),
    .o_state(dbg_state)
  );

  // Counters
  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the bus bits emitted inside the current stuffing
  // region. Whenever the last L emitted region bits are equal, the next
  // bit-time carries their complement.
  logic m_hist[$];
  bit   m_in_region = 0;
  bit   m_pending = 0;

  function automatic bit model_run_full();
    if (m_hist.size() < L) return 0;
    for (int i = m_hist.size() - L; i < m_hist.size(); i++)
      if (m_hist[i] !== m_hist[m_hist.size()-1]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_in_region = 0;
    m_pending = 0;
  endtask

  task automatic model_push(input logic b);
    m_hist.push_back(b);
    if (m_hist.size() > L) void'(m_hist.pop_front());
  endtask

  // One strobe: returns expected tx_ready and {TX, stuff_ins, underrun}.
  task automatic model_step(input logic f, input logic v, input logic b,
                            output logic rdy, output logic [2:0] exp);
    logic o;
    if (m_pending) begin
      o = ~m_hist[m_hist.size()-1];
      rdy = 1'b0;
      exp = {o, 1'b1, 1'b0};
      m_pending = 0;
      if (f) model_push(o);
      else begin
        m_in_region = 0;
        m_hist.delete();
      end
    end else begin
      o = v ? b : 1'b1;
      rdy = 1'b1;
      exp = {o, 1'b0, ~v};
      if (m_in_region) begin
        model_push(o);
        if (model_run_full()) m_pending = 1;
        else if (!f) begin
          m_in_region = 0;
          m_hist.delete();
        end
      end else if (f && v) begin
        m_in_region = 1;
        m_hist.delete();
        model_push(o);
      end
    end
  endtask

  // Scoreboard
  logic [2:0] exp_q[$];
  logic act_tx[$];
  logic act_st[$];

  // Driver tasks
  task automatic send_bit(input logic f, input logic v, input logic b);
    bit consumed = 0;
    logic rdy;
    logic [2:0] e;
    while (!consumed) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      @(negedge clock);
      SP = 1'b1; F_STF = f; tx_valid = v; tx_bit = b;
      model_step(f, v, b, rdy, e);
      exp_q.push_back(e);
      #1;
      chk("tx_ready_on_sp", {31'd0, tx_ready}, {31'd0, rdy});
      consumed = rdy;
      @(negedge clock);
      SP = 1'b0;
    end
  endtask

  task automatic do_reset(input logic with_sp);
    @(negedge clock);
    reset = 1'b1;
    SP = with_sp;
    tx_valid = 1'b1;
    tx_bit = 1'b0;
    F_STF = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    SP = 1'b0;
    act_tx.delete();
    act_st.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_log(input string name, input logic [15:0] etx,
                           input logic [15:0] est, input int n);
    chk({name, "_len"}, act_tx.size(), n);
    if (act_tx.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_tx"}, {31'd0, act_tx[i]}, {31'd0, etx[i]});
        chk({name, "_stuff"}, {31'd0, act_st[i]}, {31'd0, est[i]});
      end
    end
    act_tx.delete();
    act_st.delete();
  endtask

  // Monitor: pops one expected entry per strobe, otherwise checks hold.
  logic last_tx = 1'b1;
  logic last_st = 1'b0;

  always @(posedge clock) begin
    logic s_sp;
    logic s_rst;
    logic [2:0] e;
    s_sp = SP;
    s_rst = reset;
    #1;
    if (s_rst) begin
      chk("reset_tx", {31'd0, TX}, 32'd1);
      chk("reset_stuff", {31'd0, stuff_ins}, 32'd0);
      chk("reset_underrun", {31'd0, underrun}, 32'd0);
      last_tx = 1'b1;
      last_st = 1'b0;
    end else if (s_sp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tx", {31'd0, TX}, {31'd0, e[2]});
        chk("stuff_ins", {31'd0, stuff_ins}, {31'd0, e[1]});
        chk("underrun", {31'd0, underrun}, {31'd0, e[0]});
        last_tx = e[2];
        last_st = e[1];
      end
      act_tx.push_back(TX);
      act_st.push_back(stuff_ins);
    end else begin
      chk("hold_tx", {31'd0, TX}, {31'd0, last_tx});
      chk("hold_stuff", {31'd0, stuff_ins}, {31'd0, last_st});
      chk("underrun_idle", {31'd0, underrun}, 32'd0);
      chk("ready_idle", {31'd0, tx_ready}, 32'd0);
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic cur;
    int region_len;
    int tail_len;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    act_tx.delete();
    act_st.delete();

    // Basic stuff: 0 x5 then 1.
    for (int i = 0; i < 5; i++) send_bit(1, 1, 0);
    send_bit(1, 1, 1);
    idle_cycles(3);
    check_log("basic", 16'h0060, 16'h0020, 7);

    // Alternating bits: never stuffed.
    do_reset(0);
    for (int i = 0; i < 12; i++) send_bit(1, 1, logic'(i % 2));
    idle_cycles(3);
    check_log("alternate", 16'h0AAA, 16'h0000, 12);

    // Stuff bit starts the next run.
    do_reset(0);
    for (int i = 0; i < 5; i++) send_bit(1, 1, 0);
    for (int i = 0; i < 4; i++) send_bit(1, 1, 1);
    send_bit(0, 1, 0);
    idle_cycles(3);
    check_log("next_run", 16'h03E0, 16'h0420, 12);

    // Stuffing disabled.
    do_reset(0);
    for (int i = 0; i < 8; i++) send_bit(0, 1, 1);
    idle_cycles(3);
    check_log("disabled", 16'h00FF, 16'h0000, 8);

    // Stuff after the last CRC bit, then pass-through.
    do_reset(0);
    for (int i = 0; i < 5; i++) send_bit(1, 1, 1);
    for (int i = 0; i < 3; i++) send_bit(0, 1, 1);
    idle_cycles(3);
    check_log("crc_end", 16'h01DF, 16'h0020, 9);

    // Reset while a stuff bit is pending, together with SP.
    do_reset(0);
    for (int i = 0; i < 5; i++) send_bit(1, 1, 0);
    idle_cycles(2);
    do_reset(1);
    send_bit(1, 1, 1);
    idle_cycles(3);
    check_log("reset_in_stuff", 16'h0001, 16'h0000, 1);

    // Underrun in RUN.
    do_reset(0);
    send_bit(1, 1, 0);
    send_bit(1, 1, 0);
    send_bit(1, 0, 0);
    send_bit(0, 1, 1);
    idle_cycles(3);
    check_log("underrun_run", 16'h000C, 16'h0000, 4);

    // Randomized frames with long runs and occasional underruns.
    do_reset(0);
    cur = 1'b0;
    for (int fr = 0; fr < 40; fr++) begin
      region_len = $urandom_range(8, 40);
      send_bit(1, 1, 1'b0);
      for (int i = 0; i < region_len; i++) begin
        if ($urandom_range(0, 3) == 0) cur = ~cur;
        send_bit(1, logic'($urandom_range(0, 15) != 0), cur);
      end
      tail_len = $urandom_range(2, 8);
      for (int i = 0; i < tail_len; i++) send_bit(0, 1, logic'($urandom_range(0, 1)));
    end
    idle_cycles(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/can_tx_stuffer.md
# can_tx_stuffer

Transmit-side CAN bit stuffer. It sits between the frame serializer and the TX pin driver. It takes one frame bit per bit-time through a ready/valid handshake and drives the bus bit on each transmit-point strobe. After STUFF_LEN consecutive identical bits inside the stuffing region (SOF through CRC), it inserts one complementary stuff bit. This is the counterpart to the receive-side destuffing block.

## Interface
Parameters:
- STUFF_LEN, 5: run length that triggers a stuff bit; legal range 2..7.
- CNT_W, 3: run counter width; must satisfy 2^CNT_W > STUFF_LEN.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- SP  in  1  transmit-point strobe, one clock wide, once per bit-time.
- F_STF  in  1  stuffing region flag from the serializer; 1 = stuff (SOF..CRC), 0 = no stuffing.
- tx_bit  in  1  next frame bit.
- tx_valid  in  1  tx_bit is valid.
- tx_ready  out  1  combinational: SP & ~stuff_due; a bit is consumed when tx_valid & tx_ready.
- TX  out  1  registered bus bit; 1 = recessive.
- stuff_ins  out  1  registered; high for the bit-time in which TX carries a stuff bit.
- underrun  out  1  one-clock pulse when a bit is consumed on SP with tx_valid low.

## Operation
- State machine with states IDLE, RUN and STUFF. The state and run counter advance only on SP cycles.
- **IDLE**
  - On SP with F_STF=1 and a bit consumed: TX <= tx_bit, prev <= tx_bit, cnt <= 1, go to RUN.
  - On SP with F_STF=0: TX <= tx_bit if tx_valid, else 1. No counting.
- **RUN** (on SP, data bit b is consumed)
  - TX <= b.
  - If b==prev: cnt <= cnt+1. Otherwise cnt <= 1 and prev <= b.
  - If the new cnt equals STUFF_LEN: stuff_due <= 1, go to STUFF.
  - If F_STF=0 at this SP, the bit is sent unstuffed and counted as if F_STF=1, then go to IDLE; cnt <= 0.
- **STUFF** (on SP)
  - tx_ready is 0 and no bit is consumed.
  - TX <= ~prev, stuff_ins <= 1, prev <= ~prev, cnt <= 1, stuff_due <= 0.
  - Go to RUN if F_STF=1, else IDLE with cnt <= 0.
  - A pending stuff bit is always emitted, even if F_STF fell on this SP. This covers the stuff bit after the last CRC bit.
- The stuff bit counts as the first bit of the next run.
- Underrun: on SP in RUN or IDLE with tx_valid=0, TX <= 1, the 1 is counted in RUN exactly like data, and underrun pulses.
- Counter saturates logically at STUFF_LEN; it never wraps, because reaching STUFF_LEN always forces STUFF.

## Timing
- Reset values: TX=1, stuff_ins=0, underrun=0, tx_ready=0 (stuff_due=0 but SP gated), cnt=0, prev=1, state IDLE.
- Latency: TX updates on the clock edge at which SP is sampled high. The consumed bit is visible on TX one clock later and is held until the next SP.
- stuff_ins is updated with TX on every SP and held between strobes.
- Non-SP cycles: all state holds and tx_ready=0.
- Reset mid-frame, including in STUFF: the reset values above apply on the next edge, and any pending stuff bit is discarded.
- SP and reset together: reset wins.

## Structure
- Shared package can_pkg holds:
  - CAN_RECESSIVE=1'b1 and CAN_DOMINANT=1'b0.
  - STUFF_LEN default 5.
  - The stuffer state enum {IDLE, RUN, STUFF}, shared with the receive destuffer for common state encoding.
- No sub-module. The run counter is a few lines and stays inline.

## Test plan
- **Basic stuff:** F_STF=1, send 0,0,0,0,0,1.
  - TX = 0,0,0,0,0,1(stuff),1.
  - stuff_ins high only on the 6th bit-time; tx_ready low on that SP.
- **No stuffing on alternating bits:** F_STF=1, 12 alternating bits. No stuff_ins; TX equals the input; 12 SPs consumed.
- **Stuff bit starts the next run:** F_STF=1, send 0×5 then 1×4.
  - TX = 0×5, 1(stuff), 1×4, 0(stuff).
  - stuff_ins high on bit-times 6 and 11.
- **Stuffing disabled:** F_STF=0, send 1×8. TX = 1×8; no stuff_ins; tx_ready high on every SP.
- **Stuff after the last CRC bit:** F_STF=1 for 1×5, F_STF falls on the SP after the 5th bit.
  - TX 6th bit = 0 (stuff), stuff_ins=1.
  - Then IDLE; the next bits are passed through unstuffed.
- **Reset and underrun:** reset asserted while in STUFF.
  - Next edge: TX=1, stuff_ins=0, no stuff emitted on the following SP.
  - Separately, SP with tx_valid=0 in RUN: TX=1 and underrun pulses for one clock.
